// File: rtl/tdm_sample_bridge.sv
// TDM codec bridge: oversamples a bclk/fs/sdin serial port in the clk domain, deserializes
// 8 slots into parallel samples with a per-frame start pulse, and serializes saturated results back out.
module tdm_sample_bridge #(
  parameter int DWW        = 36,
  parameter int SampleBits = 24,
  parameter int SlotBits   = 32,
  parameter int nSlots     = 8,
  parameter int SyncStages = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         bclk,
  input  logic                         fs,
  input  logic                         sdin,
  output logic                         sdout,
  output logic [nSlots-1:0][DWW-1:0]   samples_in,
  output logic                         start,
  input  logic [nSlots-1:0][DWW-1:0]   samples_out,
  output logic                         locked,
  output logic                         frame_error
);

  localparam int FrameBits = nSlots * SlotBits;
  localparam int CntW      = $clog2(FrameBits);
  localparam int SlotW     = $clog2(nSlots);
  localparam int BitW      = $clog2(SlotBits);
  localparam logic [CntW-1:0] LastBit = CntW'(FrameBits - 1);
  localparam logic signed [DWW-1:0] SatMax = DWW'(2 ** (SampleBits - 1) - 1);
  localparam logic signed [DWW-1:0] SatMin = ~SatMax;

  typedef enum logic {HUNT, RUN} state_t;

  state_t                            state_q;
  logic [SyncStages-1:0]             bclk_sync_q, fs_sync_q, sdin_sync_q;
  logic                              bclk_last_q;
  logic [CntW-1:0]                   cnt_q, cnt_d;
  logic [nSlots-1:0][SampleBits-1:0] rx_q, tx_q, tx_sat;
  logic [nSlots-1:0][DWW-1:0]        rx_ext, samples_in_q;
  logic                              sdout_q, start_q, frame_error_q;

  logic            bclk_s, fs_s, sdin_s, rise, fall, is_sample, early_fs;
  logic [SlotW-1:0] slot_idx;
  logic [BitW-1:0]  bit_idx, tx_pos;

  assign bclk_s    = bclk_sync_q[SyncStages-1];
  assign fs_s      = fs_sync_q[SyncStages-1];
  assign sdin_s    = sdin_sync_q[SyncStages-1];
  assign rise      = bclk_s & ~bclk_last_q;
  assign fall      = ~bclk_s & bclk_last_q;

  assign slot_idx  = SlotW'(cnt_q / CntW'(SlotBits));
  assign bit_idx   = BitW'(cnt_q % CntW'(SlotBits));
  assign is_sample = bit_idx < BitW'(SampleBits);
  assign tx_pos    = BitW'(SampleBits - 1) - bit_idx;
  assign cnt_d     = (cnt_q == LastBit) ? '0 : cnt_q + CntW'(1);

  // fs at counter 0 is the regular slot-0 marker; fs on the last bit is tolerated as an early-asserting codec.
  assign early_fs  = fs_s && (cnt_q != '0) && (cnt_q != LastBit);

  for (genvar gi = 0; gi < nSlots; gi++) begin : g_slot
    logic signed [DWW-1:0] word;
    assign word        = samples_out[gi];
    assign rx_ext[gi]  = {{(DWW - SampleBits){rx_q[gi][SampleBits-1]}}, rx_q[gi]};
    assign tx_sat[gi]  = (word > SatMax) ? {1'b0, {(SampleBits - 1){1'b1}}} :
                         (word < SatMin) ? {1'b1, {(SampleBits - 1){1'b0}}} :
                                           word[SampleBits-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_sync_q   <= '0;
      fs_sync_q     <= '0;
      sdin_sync_q   <= '0;
      bclk_last_q   <= 1'b0;
      state_q       <= HUNT;
      cnt_q         <= '0;
      rx_q          <= '0;
      tx_q          <= '0;
      samples_in_q  <= '0;
      start_q       <= 1'b0;
      frame_error_q <= 1'b0;
      sdout_q       <= 1'b0;
    end else begin
      bclk_sync_q   <= {bclk_sync_q[SyncStages-2:0], bclk};
      fs_sync_q     <= {fs_sync_q[SyncStages-2:0], fs};
      sdin_sync_q   <= {sdin_sync_q[SyncStages-2:0], sdin};
      bclk_last_q   <= bclk_s;
      start_q       <= 1'b0;
      frame_error_q <= 1'b0;

      if (rise) begin
        if (state_q == HUNT) begin
          if (fs_s) begin
            rx_q[0] <= {rx_q[0][SampleBits-2:0], sdin_s};
            cnt_q   <= CntW'(1);
            state_q <= RUN;
          end
        end else if (early_fs) begin
          // Each slot is a shift register refilled by 24 new bits, so the partial frame simply gets overwritten.
          frame_error_q <= 1'b1;
          rx_q[0]       <= {rx_q[0][SampleBits-2:0], sdin_s};
          cnt_q         <= CntW'(1);
        end else begin
          if (is_sample) begin
            rx_q[slot_idx] <= {rx_q[slot_idx][SampleBits-2:0], sdin_s};
          end
          cnt_q <= cnt_d;
          if (cnt_q == LastBit) begin
            samples_in_q <= rx_ext;
            start_q      <= 1'b1;
            tx_q         <= tx_sat;
          end
        end
      end

      if (fall) begin
        sdout_q <= (state_q == RUN) && is_sample && tx_q[slot_idx][tx_pos];
      end
    end
  end

  assign sdout       = sdout_q;
  assign samples_in  = samples_in_q;
  assign start       = start_q;
  assign frame_error = frame_error_q;
  assign locked      = (state_q == RUN);

endmodule
